// File: rtl/u110_pci_arbiter.sv
// u110_pci_arbiter
//   Central PCI bus arbiter. It grants the shared bus to one of NUM_REQ slot
//   initiators or to the Amiga host initiator (index NUM_REQ). Ownership
//   rotates round-robin, and the bus parks on the host when nobody requests.
//   A granted master that leaves the bus idle for TIMEOUT clocks while still
//   requesting loses its grant.
//
// Ports
//   CLK33       PCI clock, the only clock
//   RESETn      synchronous active-low reset
//   REQn        slot requests, active-low
//   HOST_REQn   host request, active-low
//   FRAMEn      PCI FRAME#, sampled on posedge
//   IRDYn       PCI IRDY#, sampled on posedge
//   GNTn        slot grants, active-low, registered
//   HOST_GNTn   host grant, active-low, registered (low while parked)
//   ARB_OWNER   index of the current or last grantee (0..NUM_REQ), registered
//   ARB_PARKED  host holds the grant while not requesting
module u110_pci_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               CLK33,
    input  logic               RESETn,
    input  logic [NUM_REQ-1:0] REQn,
    input  logic               HOST_REQn,
    input  logic               FRAMEn,
    input  logic               IRDYn,
    output logic [NUM_REQ-1:0] GNTn,
    output logic               HOST_GNTn,
    output logic [2:0]         ARB_OWNER,
    output logic               ARB_PARKED
);

    localparam int NM = NUM_REQ + 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0]    HOST_IDX = 3'(NUM_REQ);

    typedef enum logic [1:0] {
        S_NOGNT   = 2'd0,
        S_GRANTED = 2'd1,
        S_OWNED   = 2'd2,
        S_REMOVE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NM-1:0]   gnt_q, gnt_d;

    // Active-high request vector, host in the top bit.
    logic [NM-1:0]   req;
    logic [NM-1:0]   owner_oh;
    logic            bus_idle;
    logic            owner_req;
    logic            other_req;

    assign req       = {~HOST_REQn, ~REQn};
    assign bus_idle  = FRAMEn & IRDYn;
    assign owner_oh  = NM'(1) << owner_q;
    assign owner_req = |(req & owner_oh);
    assign other_req = |(req & ~owner_oh);

    // Round-robin winner: rotate the doubled request vector so that bit 0 is
    // ARB_OWNER+1, take the lowest set bit, and map it back modulo NM.
    logic [2*NM-1:0] rot2;
    logic [NM-1:0]   rot;
    logic [3:0]      first_m;
    logic [3:0]      sum_raw;
    logic [2:0]      wsel;
    logic [2:0]      winner;

    always_comb begin
        rot2    = {req, req} >> ({1'b0, owner_q} + 4'd1);
        rot     = rot2[NM-1:0];
        first_m = 4'd0;
        for (int m = NM - 1; m >= 0; m--) begin
            if (rot[m]) first_m = 4'(m);
        end
        sum_raw = {1'b0, owner_q} + 4'd1 + first_m;
        wsel    = (sum_raw >= 4'(NM)) ? 3'(sum_raw - 4'(NM)) : 3'(sum_raw);
        winner  = (|rot) ? wsel : HOST_IDX;
    end

    // State register
    always_ff @(posedge CLK33) begin
        if (!RESETn) begin
            state_q <= S_NOGNT;
            owner_q <= HOST_IDX;
            cnt_q   <= '0;
            gnt_q   <= '1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_NOGNT: begin
                state_d = S_GRANTED;
                owner_d = winner;
                cnt_d   = '0;
            end
            S_GRANTED: begin
                if (!FRAMEn) begin
                    state_d = S_OWNED;
                end else if (bus_idle && other_req && !owner_req) begin
                    state_d = S_NOGNT;
                end else if (bus_idle && owner_req) begin
                    // A requesting owner that never starts loses the grant;
                    // the round-robin search then naturally skips it once.
                    if (cnt_q == CNT_LAST) state_d = S_NOGNT;
                    else                   cnt_d   = cnt_q + CW'(1);
                end
            end
            S_OWNED: begin
                // Preemption drops the grant immediately; the owner finishes
                // under its own latency timer while we wait in REMOVE.
                if (other_req)                   state_d = S_REMOVE;
                else if (bus_idle && !owner_req) state_d = S_NOGNT;
            end
            S_REMOVE: begin
                if (bus_idle) state_d = S_NOGNT;
            end
            default: state_d = S_NOGNT;
        endcase
        if (!FRAMEn) cnt_d = '0;
    end

    // Output logic: grants follow the next state so they change at the same
    // edge as the state they reflect.
    always_comb begin
        gnt_d = '1;
        if (state_d == S_GRANTED || state_d == S_OWNED) gnt_d = ~(NM'(1) << owner_d);
    end

    assign GNTn       = gnt_q[NUM_REQ-1:0];
    assign HOST_GNTn  = gnt_q[NUM_REQ];
    assign ARB_OWNER  = owner_q;
    assign ARB_PARKED = (state_q == S_GRANTED || state_q == S_OWNED) &&
                        (owner_q == HOST_IDX) && HOST_REQn;

endmodule

// File: tb/tb_u110_pci_arbiter.sv
module tb_u110_pci_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic         CLK33 = 1'b0;
    logic         RESETn = 1'b0;
    logic [N-1:0] REQn = '1;
    logic         HOST_REQn = 1'b1;
    logic         FRAMEn = 1'b1;
    logic         IRDYn = 1'b1;
    logic [N-1:0] GNTn;
    logic         HOST_GNTn;
    logic [2:0]   ARB_OWNER;
    logic         ARB_PARKED;

    u110_pci_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .CLK33(CLK33), .RESETn(RESETn), .REQn(REQn), .HOST_REQn(HOST_REQn),
        .FRAMEn(FRAMEn), .IRDYn(IRDYn), .GNTn(GNTn), .HOST_GNTn(HOST_GNTn),
        .ARB_OWNER(ARB_OWNER), .ARB_PARKED(ARB_PARKED)
    );

    always #5 CLK33 = ~CLK33;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = no grant (pick next edge), 1 = granted and
    // waiting, 2 = transaction running, 3 = preempted, waiting for idle.
    int m_phase = 0;
    int m_owner = N;
    int m_idle  = 0;

    task automatic model_edge();
        bit want [0:N];
        bit idle, mine, others;
        int pick;
        for (int i = 0; i <= N; i++) want[i] = (i < N) ? !REQn[i] : !HOST_REQn;
        idle   = FRAMEn && IRDYn;
        mine   = want[m_owner];
        others = 0;
        for (int i = 0; i <= N; i++) if (i != m_owner && want[i]) others = 1;
        if (!RESETn) begin
            m_phase = 0; m_owner = N; m_idle = 0;
            return;
        end
        case (m_phase)
            0: begin
                pick = N;
                for (int k = 1; k <= N + 1; k++) begin
                    if (want[(m_owner + k) % (N + 1)]) begin
                        pick = (m_owner + k) % (N + 1);
                        break;
                    end
                end
                m_owner = pick; m_phase = 1; m_idle = 0;
            end
            1: begin
                if (!FRAMEn) m_phase = 2;
                else if (idle && others && !mine) m_phase = 0;
                else if (idle && mine) begin
                    if (m_idle == TO - 1) m_phase = 0;
                    else m_idle++;
                end
            end
            2: begin
                if (others) m_phase = 3;
                else if (idle && !mine) m_phase = 0;
            end
            default: if (idle) m_phase = 0;
        endcase
        if (!FRAMEn) m_idle = 0;
    endtask

    int prev_low = -1;

    function automatic int low_idx(input logic [N:0] g);
        int r = -1;
        for (int i = 0; i <= N; i++) if (!g[i]) r = i;
        return r;
    endfunction

    // Apply one clock of inputs, step the model, then compare DUT to model
    // and check the grant invariants.
    task automatic tick(input logic rst, input logic [N-1:0] rq, input logic hr,
                        input logic fr, input logic ir);
        logic [N:0] exp_g, act_g;
        int zeros, cur;
        RESETn = rst; REQn = rq; HOST_REQn = hr; FRAMEn = fr; IRDYn = ir;
        @(posedge CLK33);
        model_edge();
        #1;
        exp_g = '1;
        if (m_phase == 1 || m_phase == 2) exp_g[m_owner] = 1'b0;
        act_g = {HOST_GNTn, GNTn};
        chk("model_gnt", int'(act_g), int'(exp_g));
        chk("model_owner", int'(ARB_OWNER), m_owner);
        chk("model_parked", int'(ARB_PARKED),
            int'((m_phase == 1 || m_phase == 2) && m_owner == N && HOST_REQn));
        zeros = 0;
        for (int i = 0; i <= N; i++) if (!act_g[i]) zeros++;
        chk("one_grant", int'(zeros <= 1), 1);
        cur = low_idx(act_g);
        chk("handover_gap", int'(prev_low >= 0 && cur >= 0 && cur != prev_low), 0);
        prev_low = cur;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] reqn;
        logic       hreqn, fr, ir;
        logic [3:0] gntn;
        logic       hg;
        logic [2:0] own;
        logic       pk;
    } vec_t;

    vec_t tv [22];

    initial begin
        int cnt, slot, got, busy, ps, cs;
        int order [4];
        logic [N-1:0] rq;
        logic fr, ir, hr, rs;

        tv[0]  = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 3'd4, 1'b0};
        tv[1]  = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 3'd4, 1'b0};
        tv[2]  = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 3'd4, 1'b0};
        tv[3]  = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 3'd4, 1'b1};
        tv[4]  = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 3'd4, 1'b1};
        tv[5]  = '{1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 3'd4, 1'b0};
        tv[6]  = '{1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 4'hB, 1'b1, 3'd2, 1'b0};
        tv[7]  = '{1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 4'hB, 1'b1, 3'd2, 1'b0};
        tv[8]  = '{1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 4'hB, 1'b1, 3'd2, 1'b0};
        tv[9]  = '{1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 3'd2, 1'b0};
        tv[10] = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 3'd2, 1'b0};
        tv[11] = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 3'd4, 1'b1};
        tv[12] = '{1'b1, 4'hE, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 3'd4, 1'b0};
        tv[13] = '{1'b1, 4'hE, 1'b1, 1'b1, 1'b1, 4'hE, 1'b1, 3'd0, 1'b0};
        tv[14] = '{1'b1, 4'hE, 1'b1, 1'b0, 1'b1, 4'hE, 1'b1, 3'd0, 1'b0};
        tv[15] = '{1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 3'd0, 1'b0};
        tv[16] = '{1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 3'd0, 1'b0};
        tv[17] = '{1'b1, 4'hE, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 3'd0, 1'b0};
        tv[18] = '{1'b1, 4'hE, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 3'd4, 1'b0};
        tv[19] = '{1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 3'd4, 1'b0};
        tv[20] = '{1'b0, 4'hE, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 3'd4, 1'b0};
        tv[21] = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 3'd4, 1'b1};

        // Directed table: reset/park, single request, preemption, mid-txn reset
        for (int i = 0; i < 22; i++) begin
            tick(tv[i].rst, tv[i].reqn, tv[i].hreqn, tv[i].fr, tv[i].ir);
            chk($sformatf("tv%0d_gntn", i), int'(GNTn), int'(tv[i].gntn));
            chk($sformatf("tv%0d_hgnt", i), int'(HOST_GNTn), int'(tv[i].hg));
            chk($sformatf("tv%0d_owner", i), int'(ARB_OWNER), int'(tv[i].own));
            chk($sformatf("tv%0d_parked", i), int'(ARB_PARKED), int'(tv[i].pk));
        end

        // Timeout: slots 1 and 3 request, nobody ever drives FRAMEn
        tick(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 4'hF, 1'b1, 1'b1, 1'b1);
        cnt = 0;
        while (GNTn[1] !== 1'b0 && cnt < 10) begin tick(1'b1, 4'b0101, 1'b1, 1'b1, 1'b1); cnt++; end
        chk("to_first_grant_slot1", int'(GNTn), int'(4'b1101));
        cnt = 0;
        while (GNTn[1] === 1'b0 && cnt < 40) begin tick(1'b1, 4'b0101, 1'b1, 1'b1, 1'b1); cnt++; end
        chk("to_length", cnt, TO);
        cnt = 0;
        while (GNTn === 4'hF && cnt < 10) begin tick(1'b1, 4'b0101, 1'b1, 1'b1, 1'b1); cnt++; end
        chk("to_next_slot3", int'(GNTn), int'(4'b0111));
        cnt = 0;
        while (GNTn[3] === 1'b0 && cnt < 40) begin tick(1'b1, 4'b0101, 1'b1, 1'b1, 1'b1); cnt++; end
        chk("to_length3", cnt, TO);
        cnt = 0;
        while (GNTn === 4'hF && cnt < 10) begin tick(1'b1, 4'b0101, 1'b1, 1'b1, 1'b1); cnt++; end
        chk("to_back_slot1", int'(GNTn), int'(4'b1101));

        // Round-robin: slots 0,1,3 request, each granted master runs 4 clocks
        tick(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 4'hF, 1'b1, 1'b1, 1'b1);
        got = 0; busy = 0; cnt = 0; ps = -1;
        while (got < 4 && cnt < 200) begin
            if (busy > 0) begin fr = 1'b0; busy--; end
            else if (GNTn !== 4'hF) begin fr = 1'b0; busy = 3; end
            else fr = 1'b1;
            tick(1'b1, 4'b0100, 1'b1, fr, fr);
            cs = -1;
            for (int i = 0; i < N; i++) if (!GNTn[i]) cs = i;
            if (cs >= 0 && ps < 0) begin order[got] = cs; got++; end
            ps = cs;
            cnt++;
        end
        chk("rr_count", got, 4);
        if (got == 4) begin
            chk("rr_0", order[0], 0);
            chk("rr_1", order[1], 1);
            chk("rr_2", order[2], 3);
            chk("rr_3", order[3], 0);
        end

        // Random traffic against the model: busy bus, then mostly idle bus
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) rq[b] = ($urandom_range(3) != 0);
            hr = ($urandom_range(3) != 0);
            if (i < 1500) begin
                fr = ($urandom_range(2) != 0);
                ir = ($urandom_range(2) != 0);
            end else begin
                fr = ($urandom_range(19) != 0);
                ir = ($urandom_range(19) != 0);
            end
            rs = ($urandom_range(99) != 0);
            tick(rs, rq, hr, fr, ir);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
